// File: rtl/bram_checker_pkg.sv
// Shared state/pattern types and the per-address pattern generator for the BRAM self-test engine.
package bram_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PAT_ADDR  = 2'd0,
    PAT_INV   = 2'd1,
    PAT_WALK  = 2'd2,
    PAT_CHECK = 2'd3
  } pat_sel_e;

  localparam logic [31:0] MASK_AA = 32'hAAAA_AAAA;
  localparam logic [31:0] MASK_55 = 32'h5555_5555;

  // Full 32-bit pattern word; the caller truncates it to its data width.
  function automatic logic [31:0] pattern_word(input logic [31:0] addr,
                                               input pat_sel_e    sel,
                                               input logic [31:0] data_w);
    logic [31:0] word;
    case (sel)
      PAT_ADDR:  word = addr;
      PAT_INV:   word = ~addr;
      PAT_WALK:  word = 32'd1 << (addr % data_w);
      PAT_CHECK: word = addr[0] ? MASK_55 : MASK_AA;
      default:   word = 32'd0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/bram_checker_rd_pipe.sv
// bram_rd_pipe: RD_LAT-deep {valid, address} delay line that tracks reads through the BRAM.
module bram_rd_pipe
  import bram_checker_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  logic [RD_LAT-1:0] vld_r;
  logic [ADDR_W-1:0] addr_r [RD_LAT];

  // Shift valid/address one stage per cycle, in step with the BRAM read path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_r <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_r[i] <= '0;
    end else begin
      vld_r[0]  <= in_valid;
      addr_r[0] <= in_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_r[i]  <= vld_r[i-1];
        addr_r[i] <= addr_r[i-1];
      end
    end
  end

  assign out_valid = vld_r[RD_LAT-1];
  assign out_addr  = addr_r[RD_LAT-1];

endmodule

// File: rtl/bram_pattern_checker.sv
// Write/read-back self-test engine for a single-port synchronous BRAM.
// Optional error injection is enabled by defining BRAM_CHECKER_ERR_INJECT_EN.
module bram_pattern_checker
  import bram_checker_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        pattern,
`ifdef BRAM_CHECKER_ERR_INJECT_EN
  input  logic              inject,
`endif
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  state_e            state_r;
  pat_sel_e          sel_r;
  logic [1:0]        drain_cnt_r;
  logic              mem_we_r, busy_r, done_r, pass_r;
  logic [ADDR_W-1:0] mem_addr_r, first_err_addr_r;
  logic [DATA_W-1:0] mem_din_r;
  logic [ERR_W-1:0]  err_count_r;

  logic              start_acc_s, last_addr_s, wr_flip_s;
  logic [ADDR_W-1:0] wr_addr_s;
  pat_sel_e          wr_sel_s;
  logic [DATA_W-1:0] wr_word_s, exp_word_s;
  logic              pipe_vld_s, mismatch_s;
  logic [ADDR_W-1:0] pipe_addr_s;

  // Next write word: address 0 with the live pattern select on start, else the following address.
  always_comb begin
    start_acc_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    last_addr_s = (mem_addr_r == ADDR_W'(DEPTH - 1));
    if (state_r == ST_WRITE) begin
      wr_addr_s = mem_addr_r + ADDR_W'(1);
      wr_sel_s  = sel_r;
    end else begin
      wr_addr_s = '0;
      wr_sel_s  = pat_sel_e'(pattern);
    end
    wr_word_s  = DATA_W'(pattern_word(32'(wr_addr_s), wr_sel_s, 32'(DATA_W))) ^ DATA_W'(wr_flip_s);
    exp_word_s = DATA_W'(pattern_word(32'(pipe_addr_s), sel_r, 32'(DATA_W)));
    mismatch_s = pipe_vld_s && (mem_dout != exp_word_s);
  end

`ifdef BRAM_CHECKER_ERR_INJECT_EN
  logic inj_flag_r;

  assign wr_flip_s = inj_flag_r && (start_acc_s || ((state_r == ST_WRITE) && !last_addr_s));

  // One-shot arm: survives start, consumed by the next word loaded for writing.
  always_ff @(posedge clk) begin
    if (!reset) inj_flag_r <= 1'b0;
    else if (wr_flip_s) inj_flag_r <= inject;
    else if (inject) inj_flag_r <= 1'b1;
    else inj_flag_r <= inj_flag_r;
  end
`else
  assign wr_flip_s = 1'b0;
`endif

  // Main sequencer with registered BRAM-side and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      sel_r       <= PAT_ADDR;
      drain_cnt_r <= 2'd0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_din_r   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_acc_s) begin
            state_r    <= ST_WRITE;
            sel_r      <= pat_sel_e'(pattern);
            mem_we_r   <= 1'b1;
            mem_addr_r <= '0;
            mem_din_r  <= wr_word_s;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (last_addr_s) begin
            state_r    <= ST_READ;
            mem_we_r   <= 1'b0;
            mem_addr_r <= '0;
            mem_din_r  <= '0;
          end else begin
            mem_addr_r <= wr_addr_s;
            mem_din_r  <= wr_word_s;
          end
        end
        ST_READ: begin
          if (last_addr_s) begin
            state_r     <= ST_DRAIN;
            mem_addr_r  <= '0;
            drain_cnt_r <= 2'd0;
          end else begin
            mem_addr_r <= mem_addr_r + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          // RD_LAT cycles to empty the pipe plus one for the last compare to land.
          if (drain_cnt_r == 2'(RD_LAT)) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (err_count_r == '0);
          end else begin
            drain_cnt_r <= drain_cnt_r + 2'd1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          mem_we_r <= 1'b0;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
          pass_r   <= 1'b0;
        end
      endcase
    end
  end

  // Error bookkeeping: saturating count and the address of the first mismatch.
  always_ff @(posedge clk) begin
    if (!reset || start_acc_s) begin
      err_count_r      <= '0;
      first_err_addr_r <= '0;
    end else if (mismatch_s) begin
      if (err_count_r != '1) err_count_r <= err_count_r + ERR_W'(1);
      if (err_count_r == '0) first_err_addr_r <= pipe_addr_s;
    end
  end

  bram_rd_pipe #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (state_r == ST_READ),
    .in_addr   (mem_addr_r),
    .out_valid (pipe_vld_s),
    .out_addr  (pipe_addr_s)
  );

  assign mem_we         = mem_we_r;
  assign mem_addr       = mem_addr_r;
  assign mem_din        = mem_din_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_count_r;
  assign first_err_addr = first_err_addr_r;

endmodule

// File: tb/tb_bram_pattern_checker.sv
// Directed bench for bram_pattern_checker: a default instance (A) and an RD_LAT=2, ERR_W=2 instance (B).
module tb_bram_pattern_checker;

  logic       clk, reset;
  logic       start_a, start_b, inject_a, inject_b;
  logic [1:0] pattern_a, pattern_b;
  logic       we_a, we_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [3:0] addr_a, addr_b, first_a, first_b;
  logic [7:0] din_a, din_b, dout_a, dout_b, rd1_b;
  logic [7:0] err_a;
  logic [1:0] err_b;

  logic [7:0]  mem_a [16];
  logic [7:0]  mem_b [16];
  int          force_addr_a;
  logic [15:0] corrupt_b;
  logic        zero_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  bram_pattern_checker dut_a (
    .clk(clk), .reset(reset), .start(start_a), .pattern(pattern_a),
`ifdef BRAM_CHECKER_ERR_INJECT_EN
    .inject(inject_a),
`endif
    .mem_we(we_a), .mem_addr(addr_a), .mem_din(din_a), .mem_dout(dout_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_err_addr(first_a)
  );

  bram_pattern_checker #(.RD_LAT(2), .ERR_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .pattern(pattern_b),
`ifdef BRAM_CHECKER_ERR_INJECT_EN
    .inject(inject_b),
`endif
    .mem_we(we_b), .mem_addr(addr_b), .mem_din(din_b), .mem_dout(dout_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_err_addr(first_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency BRAM with an optional forced-zero address.
  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= din_a;
    if (force_addr_a >= 0 && int'(addr_a) == force_addr_a) dout_a <= 8'h00;
    else dout_a <= mem_a[addr_a];
  end

  // Two-cycle-latency BRAM with per-address bit-0 corruption or all-zero reads.
  always @(posedge clk) begin
    if (we_b) mem_b[addr_b] <= din_b;
    rd1_b  <= zero_b ? 8'h00 : (mem_b[addr_b] ^ {7'd0, corrupt_b[addr_b]});
    dout_b <= rd1_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_a(input logic [1:0] p);
    @(negedge clk);
    start_a = 1'b1; pattern_a = p;
    @(negedge clk);
    start_a = 1'b0; pattern_a = ~p;
  endtask

  task automatic pulse_b(input logic [1:0] p);
    @(negedge clk);
    start_b = 1'b1; pattern_b = p;
    @(negedge clk);
    start_b = 1'b0; pattern_b = ~p;
  endtask

  task automatic wait_done(input bit use_b, input int cyc0, output int cyc_o);
    cyc_o = cyc0;
    while (((use_b ? done_b : done_a) !== 1'b1) && cyc_o < 200) begin
      @(negedge clk);
      cyc_o++;
    end
  endtask

  initial begin
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; inject_a = 1'b0; inject_b = 1'b0;
    pattern_a = 2'd0; pattern_b = 2'd0;
    force_addr_a = -1; corrupt_b = 16'h0000; zero_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_outs", 32'({we_a, addr_a, din_a, busy_a, done_a, pass_a, err_a, first_a}), 32'd0);
    check("rst_b_outs", 32'({we_b, addr_b, din_b, busy_b, done_b, pass_b, err_b, first_b}), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Pattern 0, clean memory: write sequence, latency and pass.
    pulse_a(2'd0);
    check("busy_on_start", 32'(busy_a), 32'd1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("wr_word%0d", k), 32'({we_a, addr_a, din_a}), 32'({1'b1, 4'(k), 8'(k)}));
      @(negedge clk);
    end
    check("wr_end_we", 32'(we_a), 32'd0);
    wait_done(1'b0, 16, cyc);
    check("p0_latency", 32'(cyc), 32'd34);
    check("p0_status", 32'({busy_a, pass_a, err_a, first_a}), 32'({1'b0, 1'b1, 8'd0, 4'd0}));

    // Walking one with address 5 read back as zero.
    force_addr_a = 5;
    pulse_a(2'd2);
    wait_done(1'b0, 0, cyc);
    check("p2_latency", 32'(cyc), 32'd34);
    check("p2_pass", 32'(pass_a), 32'd0);
    check("p2_err", 32'(err_a), 32'd1);
    check("p2_first", 32'(first_a), 32'd5);
    force_addr_a = -1;

    // A start pulse during WRITE must be ignored.
    pulse_a(2'd0);
    repeat (3) @(negedge clk);
    start_a = 1'b1; pattern_a = 2'd3;
    @(negedge clk);
    start_a = 1'b0;
    check("ign_start_wr", 32'({we_a, addr_a, din_a}), 32'({1'b1, 4'd4, 8'h04}));
    wait_done(1'b0, 4, cyc);
    check("ign_latency", 32'(cyc), 32'd34);
    check("ign_status", 32'({pass_a, err_a}), 32'({1'b1, 8'd0}));

    // Reset in the middle of READ, then a clean rerun.
    pulse_a(2'd1);
    repeat (20) @(negedge clk);
    check("mid_read", 32'({busy_a, we_a}), 32'({1'b1, 1'b0}));
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_outs", 32'({we_a, addr_a, din_a, busy_a, done_a, pass_a, err_a, first_a}), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    pulse_a(2'd1);
    wait_done(1'b0, 0, cyc);
    check("rerun_latency", 32'(cyc), 32'd34);
    check("rerun_status", 32'({pass_a, err_a, first_a}), 32'({1'b1, 8'd0, 4'd0}));

    // RD_LAT=2, checkerboard, addresses 3 and 9 corrupted.
    corrupt_b = 16'h0208;
    pulse_b(2'd3);
    wait_done(1'b1, 0, cyc);
    check("b_latency", 32'(cyc), 32'd35);
    check("b_err", 32'(err_b), 32'd2);
    check("b_first", 32'(first_b), 32'd3);
    check("b_pass", 32'(pass_b), 32'd0);

    // ERR_W=2 saturation with every read returning zero.
    corrupt_b = 16'h0000; zero_b = 1'b1;
    pulse_b(2'd1);
    wait_done(1'b1, 0, cyc);
    check("sat_latency", 32'(cyc), 32'd35);
    check("sat_err", 32'(err_b), 32'd3);
    check("sat_pass", 32'({done_b, pass_b}), 32'({1'b1, 1'b0}));
    zero_b = 1'b0;

`ifdef BRAM_CHECKER_ERR_INJECT_EN
    // Inject armed in IDLE corrupts only the first word of the next run.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    inject_a = 1'b1;
    @(negedge clk);
    inject_a = 1'b0;
    pulse_a(2'd0);
    check("inj_word0", 32'({we_a, addr_a, din_a}), 32'({1'b1, 4'd0, 8'h01}));
    @(negedge clk);
    check("inj_word1", 32'({we_a, addr_a, din_a}), 32'({1'b1, 4'd1, 8'h01}));
    wait_done(1'b0, 1, cyc);
    check("inj_latency", 32'(cyc), 32'd34);
    check("inj_status", 32'({pass_a, err_a, first_a}), 32'({1'b0, 8'd1, 4'd0}));
    pulse_a(2'd0);
    wait_done(1'b0, 0, cyc);
    check("inj_rerun", 32'({pass_a, err_a}), 32'({1'b1, 8'd0}));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_pattern_checker.md
Name: bram_pattern_checker

Overview:
- Self-test engine for a single-port synchronous block RAM; generalises the button-stepped 8x16 BRAM reader.
- On a start pulse (debounced button), writes a selectable data pattern to every address, reads it back and compares each word.
- Reports pass/fail, a mismatch count and the first failing address for LED or status display.
- Sits between the debouncer and the BRAM core instance in a board top level.

Parameters:
- DATA_W, 8, BRAM word width in bits (1..32).
- DEPTH, 16, number of words tested (power of two, >=2).
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- RD_LAT, 1, BRAM read latency in cycles (1 or 2).
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- start  in  1  one-cycle start pulse (debouncer PB_down).
- pattern  in  2  pattern select, sampled only when start is accepted.
- mem_we  out  1  BRAM write enable (wea).
- mem_addr  out  ADDR_W  BRAM address (addra).
- mem_din  out  DATA_W  BRAM write data (dina).
- mem_dout  in  DATA_W  BRAM read data (douta), valid RD_LAT cycles after the address.
- busy  out  1  high in WRITE, READ and DRAIN.
- done  out  1  high while in DONE.
- pass  out  1  high in DONE when err_count==0.
- err_count  out  ERR_W  mismatch count; saturates at all-ones.
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 when there is none.

Behaviour:
- Reset (reset==0 at an edge): state IDLE; all outputs 0.
  - Applies mid-run: mem_we is low from that edge; the run is discarded.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE or DONE + start: latch pattern; clear err_count, first_err_addr, pass and the address counter; go to WRITE.
  - start is ignored while busy.
- Pattern value for address a:
  - 0: a, zero-extended or truncated to DATA_W.
  - 1: bitwise ~ of pattern 0.
  - 2: walking one, 1 << (a mod DATA_W).
  - 3: checkerboard, alternating 0xAA..AA / 0x55..55 by a[0] (a[0]==0 gives AA).
- WRITE:
  - One word per cycle: mem_we=1, mem_addr counts 0..DEPTH-1, mem_din = pattern(mem_addr).
  - After address DEPTH-1, the counter wraps to 0 and the state goes to READ.
- READ:
  - mem_we=0; one read address per cycle, 0..DEPTH-1.
  - A RD_LAT-deep shift register carries {valid, expected address} alongside each read.
  - After DEPTH-1, go to DRAIN.
- DRAIN: wait RD_LAT cycles for the pipeline to empty, then go to DONE.
- Compare: whenever the pipeline output is valid, compare mem_dout with pattern(addr).
  - On mismatch: err_count += 1, saturating.
  - On the first mismatch only: capture first_err_addr.
  - Compares continue through DRAIN.
- Latency: with start sampled at edge 0, done rises at edge 2*DEPTH+RD_LAT+1.
- DONE:
  - done=1; pass=(err_count==0).
  - err_count and first_err_addr hold until the next accepted start or reset.
- mem_addr and mem_din are 0 outside WRITE and READ.

Optional Feature:
- Macro: BRAM_CHECKER_ERR_INJECT_EN.
- Defined:
  - Adds input port inject (1 bit).
  - An inject pulse arms a one-shot flag; the next WRITE word has bit 0 inverted, then the flag clears.
  - The flag is cleared by reset, not by start.
  - The run must then end with pass=0, err_count=1, first_err_addr = the corrupted address.
- Not defined: no inject port and no extra logic.

Decomposition:
- Package bram_checker_pkg holds:
  - state enum and pattern-select codes;
  - function pattern_word(addr, sel);
  - localparam AA/55 masks sized by DATA_W.
- One sub-module, bram_rd_pipe: the RD_LAT-deep valid/address delay line.

Test Plan:
- Defaults, behavioural BRAM model, pattern=0, start pulse:
  - mem_din is 0x00..0x0F on addresses 0..15 with mem_we=1;
  - done at cycle 34; pass=1; err_count=0.
- Defaults, pattern=2, model forces read of address 5 to 0x00:
  - pass=0, err_count=1, first_err_addr=5.
- DEPTH=16, RD_LAT=2, pattern=3, model corrupts addresses 3 and 9:
  - done at cycle 35; err_count=2; first_err_addr=3.
- ERR_W=2, model returns 0 for every read, pattern=1: err_count saturates at 3; pass=0.
- Robustness:
  - start during WRITE is ignored and the run completes normally.
  - reset=0 during READ gives IDLE next cycle with all outputs 0; a new start then runs cleanly.
- With BRAM_CHECKER_ERR_INJECT_EN, inject during IDLE, pattern=0:
  - address 0 is written as 0x01;
  - pass=0, err_count=1, first_err_addr=0;
  - a second run passes.
